// File: rtl/fpu_op_seq_pkg.sv
// fpu_op_seq_pkg: shared types for the bf16 FPU issue/sequencing stage.
// Contents: fp_alu_op_e (FPU operator set incl. fused multiply-add),
//           fp_seq_state_e (sequencer FSM states), FP_BF16_W (bf16 field width).
package fpu_op_seq_pkg;

  localparam int FP_BF16_W = 16;

  typedef enum logic [2:0] {
    FP_ALU_ADD   = 3'd0,
    FP_ALU_SUB   = 3'd1,
    FP_ALU_MUL   = 3'd2,
    FP_ALU_DIV   = 3'd3,
    FP_ALU_CVT   = 3'd4,
    FP_ALU_CLASS = 3'd5,
    FP_ALU_MADD  = 3'd6
  } fp_alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    RESP  = 2'd3
  } fp_seq_state_e;

endpackage

// File: rtl/fpu_op_seq.sv
// fpu_op_seq: issue/sequencing stage in front of the combinational bf16 FPU.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (sync abort of in-flight op)
//   valid_i/ready_o, operator_i, operand_a/b/c_i, mode_i : request from core
//   valid_o/ready_i, result_o                            : registered result to core
//   busy_o                                               : sequencer not idle
//   fpu_operator_o, fpu_operand_a/b_o, fpu_mode_o        : registered drive to FPU
//   fpu_result_i                                         : combinational FPU result
// Optional build macro FPU_OP_SEQ_BYPASS_EN: accept the next request in the same
// cycle the result is handed off, skipping the IDLE bubble.
module fpu_op_seq
  import fpu_op_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int FP_W = FP_BF16_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  fp_alu_op_e        operator_i,
  input  logic [XLEN-1:0]   operand_a_i,
  input  logic [XLEN-1:0]   operand_b_i,
  input  logic [XLEN-1:0]   operand_c_i,
  input  logic [1:0]        mode_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic              busy_o,
  output fp_alu_op_e        fpu_operator_o,
  output logic [XLEN-1:0]   fpu_operand_a_o,
  output logic [XLEN-1:0]   fpu_operand_b_o,
  output logic [1:0]        fpu_mode_o,
  input  logic [XLEN-1:0]   fpu_result_i
);
  fp_seq_state_e   r_state, w_state_n;
  fp_alu_op_e      r_op;
  logic [XLEN-1:0] r_a, r_b, r_c, r_result;
  logic [1:0]      r_mode;
  logic [FP_W-1:0] r_prod;
  logic            w_accept, w_madd;
`ifdef FPU_OP_SEQ_BYPASS_EN
  assign ready_o = (r_state == IDLE) || (r_state == RESP && ready_i);
`else
  assign ready_o = r_state == IDLE;
`endif
  // flush wins over a request presented in the same cycle
  assign w_accept = valid_i && ready_o && !flush_i;
  assign w_madd   = r_op == FP_ALU_MADD;
  assign valid_o  = r_state == RESP;
  assign busy_o   = r_state != IDLE;
  assign result_o = r_result;
  // FPU drive depends only on state and captured registers, never on core inputs
  assign fpu_operator_o  = r_state == EXEC2 ? (r_mode[0] ? FP_ALU_SUB : FP_ALU_ADD) :
                           w_madd ? FP_ALU_MUL : r_op;
  assign fpu_operand_a_o = r_state == EXEC2 ? {r_prod, {(XLEN-FP_W){1'b0}}} : r_a;
  assign fpu_operand_b_o = r_state == EXEC2 ? r_c : r_b;
  assign fpu_mode_o      = r_mode;
  always_comb begin
    w_state_n = flush_i            ? IDLE :
                r_state == IDLE    ? (w_accept ? EXEC1 : IDLE) :
                r_state == EXEC1   ? (w_madd ? EXEC2 : RESP) :
                r_state == EXEC2   ? RESP :
                ready_i            ? (w_accept ? EXEC1 : IDLE) : RESP;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_op     <= FP_ALU_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_mode   <= '0;
      r_prod   <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_accept) begin
        r_op   <= operator_i;
        r_a    <= operand_a_i;
        r_b    <= operand_b_i;
        r_c    <= operand_c_i;
        r_mode <= mode_i;
      end
      if (!flush_i && r_state == EXEC1 && w_madd)
        r_prod <= fpu_result_i[XLEN-1:XLEN-FP_W];
      if (!flush_i && ((r_state == EXEC1 && !w_madd) || r_state == EXEC2))
        r_result <= fpu_result_i;
    end
  end
endmodule

// File: tb/tb_fpu_op_seq.sv
// tb_fpu_op_seq: randomized self-checking bench for fpu_op_seq with a bf16 FPU stub.
module tb_fpu_op_seq;
  import fpu_op_seq_pkg::*;
  logic clk = 0, rst, flush, valid_i, ready_i, ready_o, valid_o, busy;
  fp_alu_op_e op_i, fop;
  logic [31:0] a, b, c, res, fa, fb, fres;
  logic [1:0] mode, fmode;
  int errors = 0, checks = 0;
`ifdef FPU_OP_SEQ_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif
  always #5 clk = ~clk;
  fpu_op_seq dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(op_i), .operand_a_i(a), .operand_b_i(b), .operand_c_i(c), .mode_i(mode),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(res), .busy_o(busy),
    .fpu_operator_o(fop), .fpu_operand_a_o(fa), .fpu_operand_b_o(fb), .fpu_mode_o(fmode),
    .fpu_result_i(fres)
  );
  function automatic real pow2(int n);
    real r;
    r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction
  function automatic real bf2r(logic [31:0] x);
    if (x[30:23] == 8'd0) return 0.0;
    return (x[31] ? -1.0 : 1.0) * (1.0 + real'(x[22:16]) / 128.0) * pow2(int'(x[30:23]) - 127);
  endfunction
  function automatic logic [31:0] r2bf(real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:45], 16'h0};
  endfunction
  // combinational bf16 FPU stand-in (truncating arithmetic, no MADD support)
  function automatic logic [31:0] fpu_fn(fp_alu_op_e o, logic [31:0] x, logic [31:0] y, logic [1:0] m);
    case (o)
      FP_ALU_ADD:   return r2bf(bf2r(x) + bf2r(y));
      FP_ALU_SUB:   return r2bf(bf2r(x) - bf2r(y));
      FP_ALU_MUL:   return r2bf(bf2r(x) * bf2r(y));
      FP_ALU_DIV:   return bf2r(y) == 0.0 ? 32'h0 : r2bf(bf2r(x) / bf2r(y));
      FP_ALU_CVT:   return {x[31:18], m, 16'h0};
      FP_ALU_CLASS: return {x[31], 13'h0, m, 16'h0};
      default:      return 32'h0;
    endcase
  endfunction
  // what the core should see for a whole request
  function automatic logic [31:0] ref_fn(fp_alu_op_e o, logic [31:0] x, logic [31:0] y, logic [31:0] z, logic [1:0] m);
    logic [31:0] p;
    if (o != FP_ALU_MADD) return fpu_fn(o, x, y, m);
    p = fpu_fn(FP_ALU_MUL, x, y, m);
    return fpu_fn(m[0] ? FP_ALU_SUB : FP_ALU_ADD, {p[31:16], 16'h0}, z, m);
  endfunction
  function automatic logic [31:0] rnd_bf();
    return {1'($urandom), 8'($urandom_range(124, 130)), 7'($urandom), 16'h0};
  endfunction
  assign fres = fpu_fn(fop, fa, fb, fmode);
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input fp_alu_op_e o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z, input logic [1:0] m);
    op_i = o; a = x; b = y; c = z; mode = m; valid_i = 1;
    step();
    valid_i = 0;
  endtask
  task automatic wait_valid(output int n);
    n = 1;
    while (!valid_o && n < 20) begin
      step();
      n++;
    end
  endtask
  task automatic test_reset();
    rst = 1; flush = 0; valid_i = 0; ready_i = 0; op_i = FP_ALU_ADD; a = 0; b = 0; c = 0; mode = 0;
    step(); step();
    checks++;
    if (valid_o !== 1'b0 || busy !== 1'b0 || res !== 32'h0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b busy=%b res=%h ready=%b want 0 0 0 1", valid_o, busy, res, ready_o);
    end
    checks++;
    if (fop !== FP_ALU_ADD || fa !== 32'h0 || fb !== 32'h0 || fmode !== 2'b0) begin
      errors++;
      $display("FAIL reset_fpu: op=%0d a=%h b=%h mode=%b want 0 0 0 0", fop, fa, fb, fmode);
    end
    rst = 0;
    step();
  endtask
  task automatic test_reset_mid();
    ready_i = 1;
    issue(FP_ALU_MADD, 32'h40000000, 32'h40400000, 32'h3F800000, 2'b01);
    step();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (busy !== 1'b0 || valid_o !== 1'b0 || res !== 32'h0 || fa !== 32'h0 || fop !== FP_ALU_ADD || fmode !== 2'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b valid=%b res=%h fa=%h op=%0d mode=%b want all zero", busy, valid_o, res, fa, fop, fmode);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet: valid=%b want 0", valid_o);
      end
    end
  endtask
  task automatic test_add();
    ready_i = 1;
    issue(FP_ALU_ADD, 32'h3F800000, 32'h40000000, 32'h0, 2'b00);
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL add_t1: ready=%b valid=%b busy=%b want 0 0 1", ready_o, valid_o, busy);
    end
    step();
    checks++;
    if (valid_o !== 1'b1 || res !== 32'h40400000 || ready_o !== (BYP ? ready_i : 1'b0)) begin
      errors++;
      $display("FAIL add_t2: valid=%b res=%h ready=%b want 1 40400000 %b", valid_o, res, ready_o, BYP ? ready_i : 1'b0);
    end
    step();
    checks++;
    if (valid_o !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_t3: valid=%b busy=%b want 0 0", valid_o, busy);
    end
  endtask
  task automatic test_madd(input logic [1:0] m, input logic [31:0] exp);
    ready_i = 1;
    issue(FP_ALU_MADD, 32'h40000000, 32'h40400000, 32'h3F800000, m);
    checks++;
    if (fop !== FP_ALU_MUL || fa !== 32'h40000000 || fb !== 32'h40400000 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL madd_exec1: op=%0d a=%h b=%h valid=%b want MUL 40000000 40400000 0", fop, fa, fb, valid_o);
    end
    step();
    checks++;
    if (fop !== (m[0] ? FP_ALU_SUB : FP_ALU_ADD) || fa !== 32'h40C00000 || fb !== 32'h3F800000 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL madd_exec2: op=%0d a=%h b=%h valid=%b want %0d 40c00000 3f800000 0", fop, fa, fb, valid_o, m[0] ? 1 : 0);
    end
    step();
    checks++;
    if (valid_o !== 1'b1 || res !== exp) begin
      errors++;
      $display("FAIL madd_result: valid=%b res=%h want 1 %h", valid_o, res, exp);
    end
    step();
  endtask
  task automatic test_backpressure();
    logic [31:0] x, y, e;
    int n;
    x = rnd_bf(); y = rnd_bf(); e = ref_fn(FP_ALU_ADD, x, y, 32'h0, 2'b00);
    ready_i = 0;
    issue(FP_ALU_ADD, x, y, 32'h0, 2'b00);
    wait_valid(n);
    checks++;
    if (n !== 2 || res !== e) begin
      errors++;
      $display("FAIL bp_first: latency=%0d res=%h want 2 %h", n, res, e);
    end
    op_i = FP_ALU_MUL; a = rnd_bf(); b = rnd_bf(); valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (valid_o !== 1'b1 || res !== e || ready_o !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: valid=%b res=%h ready=%b busy=%b want 1 %h 0 1", valid_o, res, ready_o, busy, e);
      end
    end
    ready_i = 1; valid_i = 0;
    step();
    checks++;
    if (busy !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: busy=%b valid=%b want 0 0", busy, valid_o);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_ignored: busy=%b want 0", busy);
    end
  endtask
  task automatic test_flush();
    int n;
    ready_i = 1;
    issue(FP_ALU_MADD, 32'h40000000, 32'h40400000, 32'h3F800000, 2'b00);
    step();
    flush = 1;
    step();
    flush = 0;
    checks++;
    if (busy !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_exec2: busy=%b valid=%b want 0 0", busy, valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet: valid=%b want 0", valid_o);
      end
    end
    issue(FP_ALU_ADD, 32'h3F800000, 32'h40000000, 32'h0, 2'b00);
    wait_valid(n);
    checks++;
    if (n !== 2 || res !== 32'h40400000) begin
      errors++;
      $display("FAIL flush_after_add: latency=%0d res=%h want 2 40400000", n, res);
    end
    step();
    op_i = FP_ALU_ADD; valid_i = 1; flush = 1;
    step();
    valid_i = 0; flush = 0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b want 0", busy);
    end
    ready_i = 0;
    issue(FP_ALU_SUB, 32'h40000000, 32'h3F800000, 32'h0, 2'b00);
    wait_valid(n);
    flush = 1;
    step();
    flush = 0;
    checks++;
    if (busy !== 1'b0 || valid_o !== 1'b0 || n !== 2) begin
      errors++;
      $display("FAIL flush_resp: busy=%b valid=%b latency=%0d want 0 0 2", busy, valid_o, n);
    end
  endtask
  task automatic test_back_to_back();
    int t1, t2;
    logic go;
    ready_i = 1; t1 = -1; t2 = -1;
    op_i = FP_ALU_ADD; a = 32'h3F800000; b = 32'h40000000; mode = 0; valid_i = 1;
    step();
    a = 32'h40000000; b = 32'h40000000;
    for (int k = 1; k < 10; k++) begin
      if (valid_o) begin
        if (t1 < 0) begin
          t1 = k;
          checks++;
          if (res !== 32'h40400000) begin
            errors++;
            $display("FAIL b2b_res1: res=%h want 40400000", res);
          end
        end else if (t2 < 0) begin
          t2 = k;
          checks++;
          if (res !== 32'h40800000) begin
            errors++;
            $display("FAIL b2b_res2: res=%h want 40800000", res);
          end
        end
      end
      go = valid_i && ready_o;
      step();
      if (go) valid_i = 0;
    end
    valid_i = 0;
    checks++;
    if (t1 !== 2 || t2 !== (BYP ? 4 : 5)) begin
      errors++;
      $display("FAIL b2b_timing: valid at %0d,%0d want 2,%0d", t1, t2, BYP ? 4 : 5);
    end
  endtask
  task automatic test_random();
    fp_alu_op_e o;
    logic [31:0] x, y, z, e;
    logic [1:0] m;
    int n, d;
    for (int i = 0; i < 40; i++) begin
      o = fp_alu_op_e'(3'($urandom_range(0, 7)));
      x = rnd_bf(); y = rnd_bf(); z = rnd_bf(); m = 2'($urandom);
      e = ref_fn(o, x, y, z, m);
      d = $urandom_range(0, 3);
      ready_i = d == 0;
      issue(o, x, y, z, m);
      wait_valid(n);
      checks++;
      if (n !== (o == FP_ALU_MADD ? 3 : 2) || res !== e) begin
        errors++;
        $display("FAIL rand_%0d op=%0d mode=%b: latency=%0d res=%h want %0d %h", i, o, m, n, res, o == FP_ALU_MADD ? 3 : 2, e);
      end
      if (d != 0) begin
        repeat (d) step();
        checks++;
        if (valid_o !== 1'b1 || res !== e) begin
          errors++;
          $display("FAIL rand_hold_%0d: valid=%b res=%h want 1 %h", i, valid_o, res, e);
        end
        ready_i = 1;
      end
      step();
      checks++;
      if (busy !== 1'b0 || valid_o !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle_%0d: busy=%b valid=%b want 0 0", i, busy, valid_o);
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_add();
    test_madd(2'b00, 32'h40E00000);
    test_madd(2'b01, 32'h40A00000);
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_op_seq.md
Name: fpu_op_seq

Overview:
- Sequential issue/sequencing stage directly upstream of the combinational bf16 FPU.
- Accepts one FP request at a time from the core over a valid/ready handshake and drives the FPU's operator, operand and mode inputs.
- Captures the FPU result and returns it over a valid/ready handshake.
- Adds fused multiply-add (FP_ALU_MADD), which the combinational FPU lacks, by sequencing two FPU passes: multiply, then add or subtract.

Parameters:
- XLEN, 32, operand/result width; bf16 values occupy bits [XLEN-1:XLEN-16], lower 16 bits are zero.
- FP_W, 16, width of the bf16 field and of the intermediate product register.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  synchronous abort of any in-flight op.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted when valid_i && ready_o.
- operator_i  in  fp_alu_op_e  requested op.
- operand_a_i  in  XLEN  rs1.
- operand_b_i  in  XLEN  rs2.
- operand_c_i  in  XLEN  rs3; used only by MADD.
- mode_i  in  2  passed to FPU; for MADD, bit0=1 selects subtract of c.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer ready.
- result_o  out  XLEN  registered result.
- busy_o  out  1  state != IDLE.
- fpu_operator_o  out  fp_alu_op_e  to FPU.
- fpu_operand_a_o  out  XLEN  to FPU.
- fpu_operand_b_o  out  XLEN  to FPU.
- fpu_mode_o  out  2  to FPU.
- fpu_result_i  in  XLEN  from FPU (combinational).

Behaviour:
- FSM states: IDLE, EXEC1, EXEC2, RESP.
- Reset: state=IDLE; valid_o=0; result_o=0; busy_o=0; all captured registers=0; fpu_* outputs=0 with operator FP_ALU_ADD.
- IDLE:
  - ready_o=1.
  - On valid_i, capture operator, a, b, c and mode; go to EXEC1.
- EXEC1:
  - fpu_* outputs are driven from the captured registers.
  - MADD: fpu_operator_o=FP_ALU_MUL; store fpu_result_i[XLEN-1:XLEN-16] into prod_q; go to EXEC2.
  - All other ops: result_q<=fpu_result_i; go to RESP.
- EXEC2:
  - fpu_operator_o = mode[0] ? FP_ALU_SUB : FP_ALU_ADD.
  - fpu_operand_a_o={prod_q,16'd0}; fpu_operand_b_o=captured c.
  - result_q<=fpu_result_i; go to RESP.
- RESP:
  - valid_o=1; result_o is held stable until the handshake completes.
  - When ready_i=1, go to IDLE; valid_o drops the next cycle.
- Latency (accept at cycle T):
  - Single-pass ops: valid_o high at T+2.
  - MADD: valid_o high at T+3.
  - Back-to-back throughput is one op per 3 cycles (single-pass) or 4 cycles (MADD).
- fpu_* outputs come from registers, not from *_i ports: no combinational path from core inputs to FPU inputs.
- ready_o=0 in EXEC1, EXEC2 and RESP; valid_i is ignored there.
- flush_i:
  - Highest priority after rst_i; from any state go to IDLE; valid_o=0 next cycle.
  - A request presented with flush_i in IDLE is NOT accepted.
- rst_i mid-operation: same as reset; the partial MADD product is discarded.
- FP_ALU_CVT and FP_ALU_CLASS are single-pass; mode passes through unchanged.
- Unknown operator: single-pass; the result is whatever the FPU returns (0).

Optional Feature:
- Macro: FPU_OP_SEQ_BYPASS_EN.
- Defined:
  - In RESP, ready_o = ready_i.
  - A request handshaken in the same cycle as the result handoff is captured, and the FSM goes RESP->EXEC1 directly.
  - Throughput becomes one op per 2 cycles (single-pass) or 3 cycles (MADD).
- Undefined: ready_o=0 in RESP, and an IDLE bubble always follows a handoff.

Decomposition:
- ibex_pkg gains:
  - fp_seq_state_e (IDLE, EXEC1, EXEC2, RESP).
  - Localparam FP_BF16_W=16.
  - FP_ALU_MADD uncommented in fp_alu_op_e.
- No sub-module; the FSM, capture registers and output register form one module.

Test Plan:
- ADD 0x3F800000 + 0x40000000, ready_i=1 -> valid_o at T+2, result_o=0x40400000 (3.0), ready_o low T+1..T+2.
- MADD a=0x40000000, b=0x40400000, c=0x3F800000, mode=00 -> EXEC2 shows fpu_operand_a_o=0x40C00000 and operator ADD; valid_o at T+3, result_o=0x40E00000 (7.0).
- MADD same operands, mode=01 -> EXEC2 operator SUB; result_o=0x40A00000 (5.0).
- Backpressure: ready_i=0 for 5 cycles after valid_o -> result_o and valid_o stable, ready_o=0, new valid_i ignored; ready_i=1 -> IDLE next cycle.
- flush_i asserted in EXEC2 of a MADD -> IDLE next cycle, valid_o never rises; a following ADD returns its correct result.
- With FPU_OP_SEQ_BYPASS_EN: two back-to-back ADDs with ready_i=1 -> valid_o at T+2 and T+4; without the macro -> T+2 and T+5.
